// File: rtl/chunked_negator_if.sv
// ---------------------------------------------------------------------------
// chunked_negator_if
// Handshake/data bundle between a producer and the chunked_negator unit.
//   in_valid / in_ready   : operand handshake (producer -> unit)
//   in_data  [WIDTH]      : operand
//   mode     [2]          : 00 pass, 01 negate, 10 abs, 11 one's complement
//   out_valid / out_ready : result handshake (unit -> consumer)
//   out_data [WIDTH]      : result
//   overflow, zero        : result flags, qualified by out_valid
// master = producer/consumer side, slave = the negator unit.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface chunked_negator_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, in_data, mode, out_ready,
    input  in_ready, out_valid, out_data, overflow, zero
  );

  modport slave (
    input  in_valid, in_data, mode, out_ready,
    output in_ready, out_valid, out_data, overflow, zero
  );
endinterface

// File: rtl/chunked_negator.sv
// ---------------------------------------------------------------------------
// chunked_negator
// Multi-cycle two's-complement negation unit. A WIDTH-bit operand is
// processed CHUNK bits per cycle through a registered ripple carry, giving
// a result NCHUNK = WIDTH/CHUNK edges after the accept edge.
// Modes: pass, negate, absolute value, one's complement.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : chunked_negator_if.slave (operand/result handshakes + flags)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module chunked_negator #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  chunked_negator_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_op;
  logic [WIDTH-1:0] r_res;
  logic             r_inv;
  logic             r_add1;
  logic             r_carry;
  logic             r_ovf;
  logic             r_zero;
  logic [CW-1:0]    r_chunk;

  logic             w_accept;
  logic             w_release;
  logic             w_last;
  logic             w_inv;
  logic             w_add1;
  logic [31:0]      w_base;
  logic [CHUNK-1:0] w_op_chunk;
  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_res;

  // in_ready is gated by reset_n so the unit never advertises readiness
  // while it is being held in reset.
  assign bus.in_ready  = reset_n && (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_data  = r_res;
  assign bus.overflow  = r_ovf;
  assign bus.zero      = r_zero;

  assign w_accept  = bus.in_valid && bus.in_ready;
  assign w_release = bus.out_valid && bus.out_ready;
  assign w_last    = (r_chunk == LAST_CHUNK);

  // Mode decode: abs behaves as negate only when the operand is negative.
  assign w_add1 = (bus.mode == 2'b01) ||
                  ((bus.mode == 2'b10) && bus.in_data[WIDTH-1]);
  assign w_inv  = w_add1 || (bus.mode == 2'b11);

  // One chunk of (inv ? ~op : op) + carry; bit CHUNK is the carry-out.
  assign w_base     = 32'(r_chunk) * 32'(CHUNK);
  assign w_op_chunk = r_op[w_base +: CHUNK];
  assign w_sum      = {1'b0, w_op_chunk ^ {CHUNK{r_inv}}} + (CHUNK+1)'(r_carry);

  // Full result with the current chunk merged in; on the last chunk this is
  // the final value the flags are computed from.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_res                   = r_res;
    w_res[w_base +: CHUNK]  = w_sum[CHUNK-1:0];
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept)  w_next_state = S_RUN;
      S_RUN:   if (w_last)    w_next_state = S_DONE;
      S_DONE:  if (w_release) w_next_state = S_IDLE;
      default:                w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op    <= '0;
      r_res   <= '0;
      r_inv   <= 1'b0;
      r_add1  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_chunk <= '0;
    end else if (w_accept) begin
      r_op    <= bus.in_data;
      r_inv   <= w_inv;
      r_add1  <= w_add1;
      r_carry <= w_add1;
      r_chunk <= '0;
    end else if (r_state == S_RUN) begin
      r_res   <= w_res;
      r_carry <= w_sum[CHUNK];
      if (w_last) begin
        // Only negate/abs of the most-negative value can overflow: the
        // result's sign matches the operand's sign although it was negated.
        r_ovf  <= r_add1 && r_op[WIDTH-1] && w_res[WIDTH-1];
        r_zero <= (w_res == '0);
      end else begin
        r_chunk <= r_chunk + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_chunked_negator.sv
`timescale 1ns/1ps
module tb_chunked_negator;

  logic clk;
  logic reset_n;

  // Shared stimulus, fanned out (truncated) to four parameterisations.
  logic [3:0]  tb_valid;
  logic [63:0] tb_data;
  logic [1:0]  tb_mode;
  logic        tb_ordy;

  logic [3:0]  w_irdy;
  logic [3:0]  w_ovalid;
  logic [3:0]  w_ovf;
  logic [3:0]  w_zero;
  logic [63:0] obs_data [4];

  int n_tests = 0;
  int n_fail  = 0;

  chunked_negator_if #(.WIDTH(64)) bus0 ();
  chunked_negator_if #(.WIDTH(64)) bus1 ();
  chunked_negator_if #(.WIDTH(8))  bus2 ();
  chunked_negator_if #(.WIDTH(32)) bus3 ();

  chunked_negator #(.WIDTH(64), .CHUNK(16)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  chunked_negator #(.WIDTH(64), .CHUNK(64)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  chunked_negator #(.WIDTH(8),  .CHUNK(1))  dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));
  chunked_negator #(.WIDTH(32), .CHUNK(8))  dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

  assign bus0.in_valid = tb_valid[0];
  assign bus1.in_valid = tb_valid[1];
  assign bus2.in_valid = tb_valid[2];
  assign bus3.in_valid = tb_valid[3];
  assign bus0.in_data  = tb_data;
  assign bus1.in_data  = tb_data;
  assign bus2.in_data  = tb_data[7:0];
  assign bus3.in_data  = tb_data[31:0];
  assign bus0.mode = tb_mode;
  assign bus1.mode = tb_mode;
  assign bus2.mode = tb_mode;
  assign bus3.mode = tb_mode;
  assign bus0.out_ready = tb_ordy;
  assign bus1.out_ready = tb_ordy;
  assign bus2.out_ready = tb_ordy;
  assign bus3.out_ready = tb_ordy;

  assign w_irdy   = {bus3.in_ready,  bus2.in_ready,  bus1.in_ready,  bus0.in_ready};
  assign w_ovalid = {bus3.out_valid, bus2.out_valid, bus1.out_valid, bus0.out_valid};
  assign w_ovf    = {bus3.overflow,  bus2.overflow,  bus1.overflow,  bus0.overflow};
  assign w_zero   = {bus3.zero,      bus2.zero,      bus1.zero,      bus0.zero};
  assign obs_data[0] = bus0.out_data;
  assign obs_data[1] = bus1.out_data;
  assign obs_data[2] = {56'd0, bus2.out_data};
  assign obs_data[3] = {32'd0, bus3.out_data};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One full transaction on instance sel: accept, wait for the result,
  // check latency/data/flags, then complete the output handshake.
  task automatic run_op(input int sel, input string tag, input logic [1:0] m,
                        input logic [63:0] d, input logic [63:0] exp_res,
                        input logic exp_ovf, input logic exp_zero, input int exp_lat);
    int  lat;
    bit  seen;
    @(negedge clk);
    check({tag, "/in_ready"}, 64'(w_irdy[sel]), 64'd1);
    tb_data       = d;
    tb_mode       = m;
    tb_valid[sel] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_valid[sel] = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = w_ovalid[sel];
    end
    check({tag, "/latency"},  64'(lat),           64'(exp_lat));
    check({tag, "/data"},     obs_data[sel],      exp_res);
    check({tag, "/overflow"}, 64'(w_ovf[sel]),    64'(exp_ovf));
    check({tag, "/zero"},     64'(w_zero[sel]),   64'(exp_zero));
    tb_ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_ordy = 1'b0;
    check({tag, "/valid_drop"}, 64'(w_ovalid[sel]), 64'd0);
    check({tag, "/ready_back"}, 64'(w_irdy[sel]),   64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tb_valid = '0;
    tb_data  = '0;
    tb_mode  = 2'b00;
    tb_ordy  = 1'b0;
    reset_n  = 1'b0;
    #2;
    check("reset/in_ready",  64'(w_irdy[0]),   64'd0);
    check("reset/out_valid", 64'(w_ovalid),    64'd0);
    check("reset/out_data",  obs_data[0],      64'd0);
    check("reset/overflow",  64'(w_ovf),       64'd0);
    check("reset/zero",      64'(w_zero),      64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset/ready_after", 64'(w_irdy), 64'hF);

    // WIDTH=64, CHUNK=16: four chunks, latency 4.
    run_op(0, "neg5",    2'b01, 64'd5,                  64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b0, 4);
    run_op(0, "neg0",    2'b01, 64'd0,                  64'd0,                   1'b0, 1'b1, 4);
    run_op(0, "negm1",   2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                  1'b0, 1'b0, 4);
    run_op(0, "abs_neg", 2'b10, 64'hFFFF_FFFF_FFFF_FFF6, 64'd10,                 1'b0, 1'b0, 4);
    run_op(0, "abs_min", 2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 4);
    run_op(0, "abs_pos", 2'b10, 64'd7,                  64'd7,                   1'b0, 1'b0, 4);
    run_op(0, "ones",    2'b11, 64'h00FF,               64'hFFFF_FFFF_FFFF_FF00, 1'b0, 1'b0, 4);
    run_op(0, "pass",    2'b00, 64'h1234,               64'h1234,                1'b0, 1'b0, 4);
    run_op(0, "neg_min", 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 4);
    run_op(0, "pass_min",2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 4);
    run_op(0, "ones_m1", 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                  1'b0, 1'b1, 4);

    // Backpressure: result held while in_valid toggles with new data.
    @(negedge clk);
    tb_data = 64'd5; tb_mode = 2'b01; tb_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("bp/valid", 64'(w_ovalid[0]), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tb_valid[0] = ~tb_valid[0];
      tb_data     = 64'hAAAA_0000_0000_0000 + 64'(i);
      tb_mode     = 2'b11;
      @(posedge clk);
      @(negedge clk);
      check("bp/hold_data",  obs_data[0],         64'hFFFF_FFFF_FFFF_FFFB);
      check("bp/hold_ovf",   64'(w_ovf[0]),       64'd0);
      check("bp/hold_zero",  64'(w_zero[0]),      64'd0);
      check("bp/hold_valid", 64'(w_ovalid[0]),    64'd1);
      check("bp/in_ready",   64'(w_irdy[0]),      64'd0);
    end
    tb_valid[0] = 1'b0;
    tb_ordy     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_ordy = 1'b0;
    check("bp/released",    64'(w_ovalid[0]), 64'd0);
    check("bp/ready_next",  64'(w_irdy[0]),   64'd1);
    check("bp/data_kept",   obs_data[0],      64'hFFFF_FFFF_FFFF_FFFB);
    run_op(0, "bp_next", 2'b01, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 4);

    // Reset during RUN chunk 2 abandons the operation.
    @(negedge clk);
    tb_data = 64'h1234; tb_mode = 2'b01; tb_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst/partial_nonzero", 64'(obs_data[0] != 64'd0), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst/out_data",  obs_data[0],      64'd0);
    check("rst/out_valid", 64'(w_ovalid[0]), 64'd0);
    check("rst/overflow",  64'(w_ovf[0]),    64'd0);
    check("rst/in_ready",  64'(w_irdy[0]),   64'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst/ready_after", 64'(w_irdy[0]), 64'd1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("rst/no_result", 64'(w_ovalid[0]), 64'd0);
    run_op(0, "rst_neg3", 2'b01, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 4);

    // WIDTH=64, CHUNK=64: RUN lasts one cycle.
    run_op(1, "w64c64_neg5", 2'b01, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b0, 1);
    run_op(1, "w64c64_min",  2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1);
    run_op(1, "w64c64_ones", 2'b11, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1);

    // WIDTH=8, CHUNK=1: eight single-bit steps.
    run_op(2, "w8c1_min",  2'b01, 64'h80, 64'h80, 1'b1, 1'b0, 8);
    run_op(2, "w8c1_neg1", 2'b01, 64'h01, 64'hFF, 1'b0, 1'b0, 8);
    run_op(2, "w8c1_abs",  2'b10, 64'hF6, 64'h0A, 1'b0, 1'b0, 8);
    run_op(2, "w8c1_ones", 2'b11, 64'h5A, 64'hA5, 1'b0, 1'b0, 8);
    run_op(2, "w8c1_neg0", 2'b01, 64'h00, 64'h00, 1'b0, 1'b1, 8);

    // WIDTH=32, CHUNK=8.
    run_op(3, "w32c8_neg",  2'b01, 64'h0000_0100, 64'hFFFF_FF00, 1'b0, 1'b0, 4);
    run_op(3, "w32c8_min",  2'b10, 64'h8000_0000, 64'h8000_0000, 1'b1, 1'b0, 4);
    run_op(3, "w32c8_abs",  2'b10, 64'hFFFF_FF00, 64'h0000_0100, 1'b0, 1'b0, 4);
    run_op(3, "w32c8_pass", 2'b00, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0, 1'b0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
